// File: rtl/div_pkg.sv
// Shared types for the divider-sharing arbiter: FSM states and response error codes.
package div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DBZ = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping mod NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int unsigned IW = $clog2(NREQ);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one multi-cycle divider between NREQ requesters with round-robin grants,
// local divide-by-zero filtering and a watchdog on the divider's done.
module div_share_arbiter import div_pkg::*; #(
    parameter int unsigned N       = 16,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_dividend,
    input  logic [NREQ*N-1:0]       req_divisor,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [N-1:0]            resp_q,
    output logic [N-1:0]            resp_r,
    output logic [1:0]              resp_err,
    output logic                    div_req,
    output logic [N-1:0]            div_dividend,
    output logic [N-1:0]            div_divisor,
    input  logic [N-1:0]            div_q,
    input  logic [N-1:0]            div_r,
    input  logic                    div_ready
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned WW = $clog2(TIMEOUT) + 1;

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic [WW-1:0] wd_cnt;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [N-1:0]    sel_dividend;
    logic [N-1:0]    sel_divisor;
    logic [IW-1:0]   next_ptr;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_dividend = req_dividend[int'(pick_idx) * N +: N];
    assign sel_divisor  = req_divisor[int'(pick_idx) * N +: N];
    assign next_ptr     = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    // Accept is combinational so a requester that drops valid before GRANT is never taken.
    assign req_ready = (state == StGrant) ? pick_grant : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= StIdle;
            rr_ptr       <= '0;
            wd_cnt       <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_q       <= '0;
            resp_r       <= '0;
            resp_err     <= ERR_OK;
            div_req      <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req_valid) state <= StGrant;
                end
                StGrant: begin
                    if (pick_any) begin
                        rr_ptr  <= next_ptr;
                        resp_id <= pick_idx;
                        if (sel_divisor == '0) begin
                            resp_q     <= '1;
                            resp_r     <= sel_dividend;
                            resp_err   <= ERR_DBZ;
                            resp_valid <= 1'b1;
                            state      <= StResp;
                        end else begin
                            div_dividend <= sel_dividend;
                            div_divisor  <= sel_divisor;
                            div_req      <= 1'b1;
                            state        <= StIssue;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StIssue: begin
                    div_req <= 1'b0;
                    wd_cnt  <= '0;
                    state   <= StWait;
                end
                StWait: begin
                    // First WAIT cycle may still see the previous op's done.
                    if (wd_cnt != '0 && div_ready) begin
                        resp_q     <= div_q;
                        resp_r     <= div_r;
                        resp_err   <= ERR_OK;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                        resp_q     <= '0;
                        resp_r     <= '0;
                        resp_err   <= ERR_TMO;
                        resp_valid <= 1'b1;
                        state      <= StResp;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a small behavioural divider model.
module tb_div_share_arbiter;

    localparam int unsigned N       = 16;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_dividend = '0;
    logic [NREQ*N-1:0] req_divisor = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [1:0]        resp_id;
    logic [N-1:0]      resp_q;
    logic [N-1:0]      resp_r;
    logic [1:0]        resp_err;
    logic              div_req;
    logic [N-1:0]      div_dividend;
    logic [N-1:0]      div_divisor;
    logic [N-1:0]      div_q;
    logic [N-1:0]      div_r;
    logic              div_ready;

    int checks = 0;
    int errors = 0;
    int div_req_cnt = 0;
    logic hang = 1'b0;

    div_share_arbiter #(
        .N       (N),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_q       (resp_q),
        .resp_r       (resp_r),
        .resp_err     (resp_err),
        .div_req      (div_req),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_ready    (div_ready)
    );

    always #5 clk = ~clk;

    // Divider model: done clears one cycle after the start pulse, so the stale done
    // of the previous op is still visible during the arbiter's first WAIT cycle.
    logic         div_seen = 1'b0;
    logic         div_busy = 1'b0;
    logic         div_done = 1'b0;
    logic [2:0]   div_cnt = '0;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '1;
    logic [N-1:0] mq = '0;
    logic [N-1:0] mr = '0;

    always @(posedge clk) begin
        div_seen <= div_req;
        if (div_req) begin
            op_a <= div_dividend;
            op_b <= div_divisor;
        end
        if (div_seen) begin
            div_done <= 1'b0;
            div_busy <= 1'b1;
            div_cnt  <= 3'd3;
        end else if (div_busy) begin
            if (div_cnt == 3'd1) begin
                div_done <= 1'b1;
                mq       <= op_a / op_b;
                mr       <= op_a % op_b;
                div_busy <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 3'd1;
            end
        end
    end

    assign div_ready = div_done & ~hang;
    assign div_q     = mq;
    assign div_r     = mr;

    always @(negedge clk) if (div_req) div_req_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_dividend[i*N +: N] = N'(a);
        req_divisor[i*N +: N]  = N'(b);
    endtask

    // Returns #1 after the posedge on which the grant transferred.
    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk(tag, 64'(req_ready), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag, input int id, input int q, input int r,
                             input int err);
        int n;
        n = 0;
        while (!resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_id"}, 64'(resp_id), 64'(id));
        chk({tag, "_q"}, 64'(resp_q), 64'(q));
        chk({tag, "_r"}, 64'(resp_r), 64'(r));
        chk({tag, "_err"}, 64'(resp_err), 64'(err));
    endtask

    task automatic drop_resp(input string tag);
        @(negedge clk);
        chk({tag, "_drop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int base;
        int n;
        int w;
        logic [N-1:0] ca [4];
        logic [N-1:0] cb [4];
        logic [N-1:0] cq [4];
        logic [N-1:0] cr [4];

        // Reset values
        #1;
        chk("rst_ctrl", 64'({req_ready, resp_valid, div_req}), 64'd0);
        chk("rst_resp", 64'({resp_id, resp_q, resp_r, resp_err}), 64'd0);
        chk("rst_div", 64'({div_dividend, div_divisor}), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // 1: single op on requester 0
        base = div_req_cnt;
        set_op(0, 100, 7);
        req_valid = 4'b0001;
        wait_grant("t1_grant", 4'b0001);
        req_valid = '0;
        chk("t1_issue", 64'(div_req), 64'd1);
        chk("t1_opnd", 64'({div_dividend, div_divisor}), 64'({16'd100, 16'd7}));
        wait_resp("t1", 0, 14, 2, 0);
        chk("t1_divreq_cycles", 64'(div_req_cnt - base), 64'd1);
        drop_resp("t1");

        // 2: divide by zero on requester 2, answered one cycle after GRANT
        base = div_req_cnt;
        set_op(2, 55, 0);
        req_valid = 4'b0100;
        wait_grant("t2_grant", 4'b0100);
        req_valid = '0;
        @(negedge clk);
        chk("t2_latency", 64'(resp_valid), 64'd1);
        wait_resp("t2", 2, 16'hFFFF, 55, 1);
        drop_resp("t2");
        chk("t2_no_divreq", 64'(div_req_cnt - base), 64'd0);

        // Requester 3 moves rr_ptr back to 0; stale done of op 1 must be ignored
        set_op(3, 200, 9);
        req_valid = 4'b1000;
        wait_grant("t2b_grant", 4'b1000);
        req_valid = '0;
        wait_resp("t2b", 3, 22, 2, 0);
        drop_resp("t2b");

        // 3: contention, all four valid
        ca = '{16'd1000, 16'd77, 16'd65535, 16'd12};
        cb = '{16'd10, 16'd5, 16'd256, 16'd13};
        cq = '{16'd100, 16'd15, 16'd255, 16'd0};
        cr = '{16'd0, 16'd2, 16'd255, 16'd12};
        for (int i = 0; i < 4; i++) set_op(i, int'(ca[i]), int'(cb[i]));
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = g % 4;
            wait_grant("t3_grant", 4'(1 << w));
            if (g == 4) req_valid = '0;
            wait_resp("t3", w, int'(cq[w]), int'(cr[w]), 0);
            drop_resp("t3");
        end

        // 4: backpressure with another requester waiting
        resp_ready = 1'b0;
        set_op(1, 50, 6);
        set_op(3, 21, 4);
        req_valid = 4'b0010;
        wait_grant("t4_grant", 4'b0010);
        req_valid = 4'b1000;
        wait_resp("t4", 1, 8, 2, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_stable", 64'({resp_valid, resp_id, resp_q, resp_r, resp_err}),
                64'({1'b1, 2'd1, 16'd8, 16'd2, 2'd0}));
            chk("t4_no_grant", 64'({req_ready, div_req}), 64'd0);
        end
        resp_ready = 1'b1;
        drop_resp("t4");
        wait_grant("t4b_grant", 4'b1000);
        req_valid = '0;
        wait_resp("t4b", 3, 5, 1, 0);
        drop_resp("t4b");

        // 5: hung divider trips the watchdog
        hang = 1'b1;
        set_op(0, 30, 5);
        req_valid = 4'b0001;
        wait_grant("t5_grant", 4'b0001);
        req_valid = '0;
        chk("t5_issue", 64'(div_req), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 200);
        chk("t5_timeout_cycles", 64'(n), 64'(TIMEOUT + 2));
        wait_resp("t5", 0, 0, 0, 2);
        drop_resp("t5");
        hang = 1'b0;
        set_op(1, 47, 4);
        req_valid = 4'b0010;
        wait_grant("t5b_grant", 4'b0010);
        req_valid = '0;
        wait_resp("t5b", 1, 11, 3, 0);
        drop_resp("t5b");

        // 6: asynchronous reset in WAIT
        set_op(2, 80, 9);
        req_valid = 4'b0100;
        wait_grant("t6_grant", 4'b0100);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_ctrl", 64'({req_ready, resp_valid, div_req}), 64'd0);
        chk("t6_rst_resp", 64'({resp_id, resp_q, resp_r, resp_err}), 64'd0);
        chk("t6_rst_div", 64'({div_dividend, div_divisor}), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_lost_op", 64'({resp_valid, div_req}), 64'd0);
        end
        // rr_ptr back at 0 picks requester 1 over 3
        set_op(1, 9, 3);
        set_op(3, 9, 3);
        req_valid = 4'b1010;
        wait_grant("t6b_grant", 4'b0010);
        req_valid = '0;
        wait_resp("t6b", 1, 3, 0, 0);
        drop_resp("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
